// File: rtl/uop_issue_queue.sv
// Purpose: in-order uop queue between decode and execute; accepts 1-3 uops per feed beat, issues one per cycle.
// Latency: a uop written at edge k can appear on uop_out after edge k (visible from cycle k+1); no bypass.
// Backpressure: feed_req drops when fewer than 3 slots are free or on flush; execute stalls via uop_ready.
module uop_issue_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 20,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  output logic [UOP_W-1:0] uop_out,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [LVL_W-1:0] level,
  output logic             ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] lvl_q;
  logic             ovf_q;

  logic [1:0]       n_wr;
  logic [UOP_W-1:0] wdat [3];
  logic             wr_en;
  logic             pop;
  logic [LVL_W-1:0] add_lvl;

  // Room for a worst-case 3-uop beat is judged on registered level only.
  assign feed_req  = (lvl_q <= LVL_W'(DEPTH - 3)) & ~flush;
  assign wr_en     = feed_ack & feed_req;
  assign uop_valid = (lvl_q != '0);
  assign pop       = uop_valid & uop_ready;
  assign uop_out   = mem[rd_ptr];
  assign level     = lvl_q;
  assign ovf_err   = ovf_q;
  assign add_lvl   = wr_en ? LVL_W'(n_wr) : '0;

  // Decode the beat into a count and program-ordered write data (first uop goes to wr_ptr).
  always_comb begin
    n_wr    = 2'd3;
    wdat[0] = uop_0;
    wdat[1] = uop_0;
    wdat[2] = uop_0;
    case (uop_count)
      2'b00: begin
        n_wr    = 2'd1;
        wdat[0] = uop_0;
      end
      2'b01: begin
        n_wr    = 2'd2;
        wdat[0] = uop_1;
        wdat[1] = uop_0;
      end
      default: begin
        n_wr    = 2'd3;
        wdat[0] = uop_2;
        wdat[1] = uop_1;
        wdat[2] = uop_0;
      end
    endcase
  end

  // Storage writes; slot indices wrap naturally through PTR_W-bit addition.
  always_ff @(posedge clk) begin
    if (!a_rst && wr_en) begin
      for (int i = 0; i < 3; i++) begin
        if (i < int'(n_wr)) begin
          mem[wr_ptr + PTR_W'(i)] <= wdat[i];
        end
      end
    end
  end

  // Pointer, level and sticky overflow state; reset dominates flush, flush dominates traffic.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (feed_ack && !feed_req) begin
        ovf_q <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        lvl_q  <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_W'(n_wr);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        lvl_q <= lvl_q + add_lvl - LVL_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Purpose: randomized and directed stimulus for uop_issue_queue against a queue-based reference model.
// Latency: model state advances once per rising edge; outputs are compared mid-cycle before that edge.
// Backpressure: decode side honours feed_req except for deliberate protocol violations.
module tb_uop_issue_queue;

  localparam int DEPTH = 8;
  localparam int UOP_W = 20;
  localparam int LVL_W = 4;

  logic             clk;
  logic             a_rst;
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [UOP_W-1:0] uop_0;
  logic [UOP_W-1:0] uop_1;
  logic [UOP_W-1:0] uop_2;
  logic [1:0]       uop_count;
  logic [UOP_W-1:0] uop_out;
  logic             uop_valid;
  logic             uop_ready;
  logic [LVL_W-1:0] level;
  logic             ovf_err;

  uop_issue_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W), .LVL_W(LVL_W)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush), .feed_req(feed_req), .feed_ack(feed_ack),
    .uop_0(uop_0), .uop_1(uop_1), .uop_2(uop_2), .uop_count(uop_count),
    .uop_out(uop_out), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .level(level), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue contents in program order plus the sticky error flag.
  logic [UOP_W-1:0] mq[$];
  bit               m_ovf;
  int               n_vec;
  int               n_bad;
  int               tag_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_room(input bit fl);
    return (mq.size() <= DEPTH - 3) && !fl;
  endfunction

  // One clock: apply inputs, compare outputs to the model, then advance the model across the edge.
  task automatic step(input bit rst, input bit fl, input bit ack, input logic [1:0] cnt,
                      input logic [UOP_W-1:0] u0, input logic [UOP_W-1:0] u1,
                      input logic [UOP_W-1:0] u2, input bit rdy);
    bit room;
    a_rst = rst; flush = fl; feed_ack = ack; uop_count = cnt;
    uop_0 = u0; uop_1 = u1; uop_2 = u2; uop_ready = rdy;
    #1;
    room = model_room(fl);
    chk("level", 32'(level), 32'(mq.size()));
    chk("uop_valid", 32'(uop_valid), 32'(mq.size() != 0));
    chk("feed_req", 32'(feed_req), 32'(room));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (mq.size() != 0) chk("uop_out", 32'(uop_out), 32'(mq[0]));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (ack && !room) m_ovf = 1'b1;
      if (fl) begin
        mq.delete();
      end else begin
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (ack && room) begin
          if (cnt >= 2) mq.push_back(u2);
          if (cnt >= 1) mq.push_back(u1);
          mq.push_back(u0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 2'b00, '0, '0, '0, rdy);
  endtask

  initial begin
    bit   rdy_r, ack_r, fl_r, rst_r;
    n_vec = 0; n_bad = 0; tag_n = 0;
    m_ovf = 1'b0;
    a_rst = 1'b1; flush = 1'b0; feed_ack = 1'b0; uop_count = 2'b00;
    uop_0 = '0; uop_1 = '0; uop_2 = '0; uop_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete();

    // Reset state, then one 3-uop instruction drained in order.
    step(1, 0, 0, 2'b00, '0, '0, '0, 0);
    step(0, 0, 1, 2'b10, 20'h00000, 20'h00001, 20'h00002, 1);
    repeat (4) idle(1);

    // Fill to full with uop_ready low; feed_req falls at level 6.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b00, 20'h10 + 20'(i), '0, '0, 0);
    step(0, 0, 1, 2'b10, 20'h17, 20'h16, 20'h15, 0);
    idle(0);
    // Protocol violation while full, then drain with error still sticky.
    step(0, 0, 1, 2'b00, 20'hBAD, '0, '0, 0);
    repeat (10) idle(1);

    // Steady stream of 2-uop instructions every other cycle.
    step(1, 0, 0, 2'b00, '0, '0, '0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, 2'b01, 20'h20000 + 20'(2 * i + 1), 20'h20000 + 20'(2 * i), '0, 1);
      idle(1);
    end
    repeat (3) idle(1);

    // Flush at level 5 with a same-cycle beat and pop.
    step(1, 0, 0, 2'b00, '0, '0, '0, 0);
    step(0, 0, 1, 2'b10, 20'h31, 20'h32, 20'h33, 0);
    step(0, 0, 1, 2'b01, 20'h34, 20'h35, '0, 0);
    step(0, 1, 1, 2'b10, 20'hDEAD, 20'hDEAD, 20'hDEAD, 1);
    repeat (3) idle(1);

    // Move both pointers to 6, then a 3-uop beat straddling the wrap.
    step(1, 0, 0, 2'b00, '0, '0, '0, 0);
    step(0, 0, 1, 2'b10, 20'h40, 20'h41, 20'h42, 0);
    step(0, 0, 1, 2'b10, 20'h43, 20'h44, 20'h45, 0);
    repeat (6) idle(1);
    step(0, 0, 1, 2'b10, 20'h50, 20'h51, 20'h52, 0);
    repeat (4) idle(1);

    // Randomized traffic; decode mostly honours feed_req, occasionally violates it.
    for (int i = 0; i < 3000; i++) begin
      rst_r = ($urandom_range(0, 299) == 0);
      fl_r  = ($urandom_range(0, 39) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      if (model_room(fl_r)) ack_r = ($urandom_range(0, 2) != 0);
      else                  ack_r = ($urandom_range(0, 63) == 0);
      step(rst_r, fl_r, ack_r, 2'($urandom_range(0, 3)),
           20'($urandom), 20'($urandom), 20'($urandom), rdy_r);
    end
    repeat (10) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
